// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - MDIO/MDC management master, Clause 22 and optional Clause 45 framing
//
// Serialises one PHY management command per start/ready handshake, MSB first, and returns
// read data with a one-cycle rd_valid strobe.
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   start, ready         command handshake (start sampled only while ready=1)
//   clause45, opcode     frame type (ST=00 for C45, ST=01 for C22) and OP field
//   phy_addr, reg_addr   PHYAD/PRTAD and REGAD/DEVAD
//   wr_data              write data, or C45 address for opcode 00
//   no_preamble          skip the preamble for this command
//   cmd_err              one-cycle pulse when an illegal C22 opcode is rejected
//   rd_data, rd_valid    last read result and its one-cycle update strobe
//   mdc                  management clock
//   mdio_out, mdio_oe    serial data and pin drive enable toward the PHY
//   mdio_in              serial data from the PHY pin

module mdio_master #(
    parameter int CLK_DIV       = 4,
    parameter int PREAMBLE_BITS = 32,
    parameter int ENABLE_C45    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clause45,
    input  logic [1:0]  opcode,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    input  logic        no_preamble,
    output logic        ready,
    output logic        cmd_err,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    localparam int              DIV_W    = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]      PRE_LAST = (PREAMBLE_BITS > 0) ? 6'(PREAMBLE_BITS - 1) : 6'd0;
    localparam bit              HAS_PRE  = (PREAMBLE_BITS > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_IDLE_BIT
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q;
    logic [15:0]      shift_q;

    logic             cmd_c45_q;
    logic [1:0]       cmd_op_q;
    logic [4:0]       cmd_phy_q;
    logic [4:0]       cmd_reg_q;
    logic [15:0]      cmd_wd_q;

    logic             c45_in;
    logic             cmd_ok;
    logic             accept;
    logic             bit_end;

    logic             cur_c45;
    logic [1:0]       cur_op;
    logic [4:0]       cur_phy;
    logic [4:0]       cur_reg;
    logic [15:0]      cur_wd;
    logic [13:0]      hdr;
    logic             nxt_out;
    logic             nxt_oe;

    assign ready   = (state_q == S_IDLE);
    assign c45_in  = (ENABLE_C45 != 0) ? clause45 : 1'b0;
    assign cmd_ok  = c45_in || (opcode == 2'b01) || (opcode == 2'b10);
    assign accept  = start && ready;
    // A bit ends on the clk where mdc falls back to 0.
    assign bit_end = (state_q != S_IDLE) && mdc && (div_cnt_q == DIV_LAST);

    // Next-state and next-bit selection
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && cmd_ok) begin
                    state_d   = (HAS_PRE && !no_preamble) ? S_PRE : S_HDR;
                    bit_cnt_d = 6'd0;
                end
            end
            S_PRE: begin
                if (bit_end) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = S_HDR;
                        bit_cnt_d = 6'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_HDR: begin
                if (bit_end) begin
                    if (bit_cnt_q == 6'd13) begin
                        state_d   = S_TA;
                        bit_cnt_d = 6'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_TA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 6'd1) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 6'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 6'd15) begin
                        state_d   = S_IDLE_BIT;
                        bit_cnt_d = 6'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_IDLE_BIT: begin
                if (bit_end) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = 6'd0;
            end
        endcase
    end

    // Pin value for the bit that starts when state_d/bit_cnt_d take effect. On the accept
    // cycle the command is not latched yet, so the live inputs supply the first bit.
    always_comb begin
        cur_c45 = cmd_c45_q;
        cur_op  = cmd_op_q;
        cur_phy = cmd_phy_q;
        cur_reg = cmd_reg_q;
        cur_wd  = cmd_wd_q;
        if (state_q == S_IDLE) begin
            cur_c45 = c45_in;
            cur_op  = opcode;
            cur_phy = phy_addr;
            cur_reg = reg_addr;
            cur_wd  = wr_data;
        end
        hdr     = {(cur_c45 ? 2'b00 : 2'b01), cur_op, cur_phy, cur_reg};
        nxt_out = 1'b1;
        nxt_oe  = 1'b0;
        case (state_d)
            S_PRE: begin
                nxt_oe = 1'b1;
            end
            S_HDR: begin
                nxt_oe  = 1'b1;
                nxt_out = hdr[4'd13 - bit_cnt_d[3:0]];
            end
            S_TA: begin
                if (!cur_op[1]) begin
                    nxt_oe  = 1'b1;
                    nxt_out = (bit_cnt_d == 6'd0);
                end
            end
            S_DATA: begin
                if (!cur_op[1]) begin
                    nxt_oe  = 1'b1;
                    nxt_out = cur_wd[4'd15 - bit_cnt_d[3:0]];
                end
            end
            default: begin
                nxt_out = 1'b1;
                nxt_oe  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 6'd0;
            div_cnt_q <= '0;
            shift_q   <= 16'd0;
            cmd_c45_q <= 1'b0;
            cmd_op_q  <= 2'b00;
            cmd_phy_q <= 5'd0;
            cmd_reg_q <= 5'd0;
            cmd_wd_q  <= 16'd0;
            mdc       <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oe   <= 1'b0;
            cmd_err   <= 1'b0;
            rd_data   <= 16'd0;
            rd_valid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_err   <= 1'b0;
            rd_valid  <= 1'b0;
            if (state_q == S_IDLE) begin
                div_cnt_q <= '0;
                mdc       <= 1'b0;
                if (accept) begin
                    if (cmd_ok) begin
                        cmd_c45_q <= c45_in;
                        cmd_op_q  <= opcode;
                        cmd_phy_q <= phy_addr;
                        cmd_reg_q <= reg_addr;
                        cmd_wd_q  <= wr_data;
                        mdio_out  <= nxt_out;
                        mdio_oe   <= nxt_oe;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
            end else if (div_cnt_q == DIV_LAST) begin
                div_cnt_q <= '0;
                mdc       <= ~mdc;
                if (!mdc) begin
                    // mdc rising: capture read data
                    if (state_q == S_DATA && cmd_op_q[1]) begin
                        shift_q <= {shift_q[14:0], mdio_in};
                    end
                end else begin
                    // mdc falling: present the next bit
                    mdio_out <= nxt_out;
                    mdio_oe  <= nxt_oe;
                    if (state_q == S_IDLE_BIT && cmd_op_q[1]) begin
                        rd_data  <= shift_q;
                        rd_valid <= 1'b1;
                    end
                end
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end

endmodule
